// File: rtl/mips_run_controller.sv
// mips_run_controller
//   Sequences one mips_cpu_harvard through a complete program run. The CPU is
//   held in reset for RESET_CYCLES enabled edges, then released and clocked
//   (free-run, or one cycle per step pulse) until it fetches HALT_ADDR or the
//   MAX_CYCLES budget runs out. register_v0 is then captured as the result.
//
// Ports
//   clk, reset          system clock; synchronous active-high controller reset
//   start               pulse; begins a run from IDLE or DONE
//   abort               level; returns to IDLE from RST/RUN/CAPTURE
//   step_mode           1 = single-step, sampled with start
//   step                pulse; grants one enabled CPU cycle in step mode
//   cpu_instr_address   CPU instr_address (halt detection)
//   cpu_register_v0     CPU register_v0 (run result)
//   cpu_reset           to CPU reset
//   cpu_clk_enable      to CPU clk_enable
//   busy                high in RST, RUN, CAPTURE
//   done                high in DONE
//   timeout             valid while done; 1 = budget exhausted without halt
//   result_v0           captured register_v0, valid while done
//   cycle_count         enabled RUN cycles in the current/last run
module mips_run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  input  logic [31:0]      cpu_instr_address,
  input  logic [31:0]      cpu_register_v0,
  output logic             cpu_reset,
  output logic             cpu_clk_enable,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      result_v0,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [7:0]       RST_LAST = 8'(RESET_CYCLES - 1);

  state_e           state_q;
  logic [7:0]       rst_cnt_q;
  logic             step_mode_q;
  logic             cpu_reset_q;
  logic             cpu_clk_enable_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic [31:0]      result_v0_q;
  logic [CNT_W-1:0] cycle_count_q;

  logic             run_tick;
  logic [CNT_W-1:0] count_d;
  logic             halt_hit;
  logic             limit_hit;
  logic             in_busy;
  logic             start_ok;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every signal on
    // every path, so no latch can be inferred.
    run_tick  = (state_q == S_RUN) && cpu_clk_enable_q;
    count_d   = cycle_count_q + CNT_W'(1);
    halt_hit  = (cpu_instr_address == HALT_ADDR);
    limit_hit = (count_d == MAX_CNT);
    in_busy   = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_CAPTURE);
    // abort beats a coincident start even where abort itself does nothing.
    start_ok  = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Outputs are registered: each branch loads the values that belong to the
  // state being entered, so they line up with state_q on the next cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q          <= S_IDLE;
      rst_cnt_q        <= '0;
      step_mode_q      <= 1'b0;
      cpu_reset_q      <= 1'b1;
      cpu_clk_enable_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      timeout_q        <= 1'b0;
      result_v0_q      <= '0;
      cycle_count_q    <= '0;
    end else begin
      // The enabled cycle has already clocked the CPU, so it is counted even
      // when abort wins the state transition.
      if (run_tick) cycle_count_q <= count_d;

      if (in_busy && abort) begin
        state_q          <= S_IDLE;
        cpu_reset_q      <= 1'b1;
        cpu_clk_enable_q <= 1'b0;
        busy_q           <= 1'b0;
        done_q           <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (start_ok) begin
              state_q          <= S_RST;
              rst_cnt_q        <= '0;
              step_mode_q      <= step_mode;
              cycle_count_q    <= '0;
              timeout_q        <= 1'b0;
              result_v0_q      <= '0;
              cpu_reset_q      <= 1'b1;
              cpu_clk_enable_q <= 1'b1;
              busy_q           <= 1'b1;
              done_q           <= 1'b0;
            end
          end
          S_RST: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q          <= S_RUN;
              cpu_reset_q      <= 1'b0;
              // Steps seen during RST are dropped; step mode starts idle.
              cpu_clk_enable_q <= !step_mode_q;
            end else begin
              rst_cnt_q <= rst_cnt_q + 8'd1;
            end
          end
          S_RUN: begin
            if (run_tick && (halt_hit || limit_hit)) begin
              // Halt beats the budget when both land on the same cycle.
              state_q          <= S_CAPTURE;
              timeout_q        <= !halt_hit;
              cpu_clk_enable_q <= 1'b0;
            end else begin
              // A step in cycle N grants exactly cycle N+1.
              cpu_clk_enable_q <= step_mode_q ? step : 1'b1;
            end
          end
          S_CAPTURE: begin
            state_q     <= S_DONE;
            result_v0_q <= cpu_register_v0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
          default: begin
            state_q          <= S_IDLE;
            cpu_reset_q      <= 1'b1;
            cpu_clk_enable_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cpu_reset      = cpu_reset_q;
  assign cpu_clk_enable = cpu_clk_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign result_v0      = result_v0_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller
//   Drives mips_run_controller with directed scenarios and random traffic and
//   compares every output, every cycle, against a run-level behavioural model.
//   The bench plays the CPU: it presents a halt fetch at a chosen enabled cycle.
module tb_mips_run_controller;

  localparam int          RC   = 2;
  localparam int          MAXC = 20;
  localparam logic [31:0] HALT = 32'h0000_0000;
  localparam int          CW   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [31:0]   cpu_instr_address = 32'h0040_0000;
  logic [31:0]   cpu_register_v0 = 32'h0;
  logic          cpu_reset;
  logic          cpu_clk_enable;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [31:0]   result_v0;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  mips_run_controller #(
    .RESET_CYCLES(RC),
    .MAX_CYCLES  (MAXC),
    .HALT_ADDR   (HALT),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .step_mode        (step_mode),
    .step             (step),
    .cpu_instr_address(cpu_instr_address),
    .cpu_register_v0  (cpu_register_v0),
    .cpu_reset        (cpu_reset),
    .cpu_clk_enable   (cpu_clk_enable),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout),
    .result_v0        (result_v0),
    .cycle_count      (cycle_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_CAP = 3, P_DONE = 4;

  int          m_phase    = P_IDLE;
  int          m_rst_left = 0;
  bit          m_smode    = 1'b0;
  bit          m_en       = 1'b0;   // CPU enable the controller grants this cycle
  int          m_count    = 0;
  bit          m_to       = 1'b0;
  logic [31:0] m_res      = 32'h0;

  int          halt_at = 0;         // enabled cycle whose fetch is HALT; 0 = never
  bit          v0_rand = 1'b1;
  logic [31:0] v0_val  = 32'h0;
  bit          cmp_on  = 1'b0;

  task automatic model_step();
    bit ran;
    bit busy_phase;
    if (reset) begin
      m_phase = P_IDLE; m_en = 1'b0; m_count = 0; m_to = 1'b0; m_res = 32'h0;
    end else begin
      ran        = (m_phase == P_RUN) && m_en;
      busy_phase = (m_phase == P_RST) || (m_phase == P_RUN) || (m_phase == P_CAP);
      if (ran) m_count++;
      if (busy_phase && abort) begin
        m_phase = P_IDLE;
        m_en    = 1'b0;
      end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
        if (start && !abort) begin
          m_phase = P_RST; m_rst_left = RC; m_smode = step_mode;
          m_count = 0; m_to = 1'b0; m_res = 32'h0; m_en = 1'b1;
        end
      end else if (m_phase == P_RST) begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          m_phase = P_RUN;
          m_en    = !m_smode;
        end
      end else if (m_phase == P_RUN) begin
        if (ran && cpu_instr_address == HALT) begin
          m_phase = P_CAP; m_to = 1'b0; m_en = 1'b0;
        end else if (ran && m_count == MAXC) begin
          m_phase = P_CAP; m_to = 1'b1; m_en = 1'b0;
        end else begin
          m_en = m_smode ? step : 1'b1;
        end
      end else begin
        m_res   = cpu_register_v0;
        m_phase = P_DONE;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Bench-as-CPU: fetch address and v0 for the coming cycle.
  always @(negedge clk) begin
    cpu_instr_address = (halt_at != 0 && m_count + 1 == halt_at) ? HALT
                                                                 : 32'h0040_0000 + 32'(m_count) * 4;
    cpu_register_v0   = v0_rand ? $urandom() : v0_val;
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cpu_reset",      32'(cpu_reset),      32'(m_phase == P_IDLE || m_phase == P_RST));
      check("cpu_clk_enable", 32'(cpu_clk_enable), 32'(m_en));
      check("busy",           32'(busy),           32'(m_phase == P_RST || m_phase == P_RUN || m_phase == P_CAP));
      check("done",           32'(done),           32'(m_phase == P_DONE));
      check("timeout",        32'(timeout),        32'(m_to));
      check("result_v0",      result_v0,           m_res);
      check("cycle_count",    cycle_count,         32'(m_count));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input bit sm, input int h);
    halt_at   = h;
    step_mode = sm;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Walks the busy window, bounded; optionally pulses start at busy cycle start_at.
  task automatic run_to_done(input int start_at, output int nb, output int low_n,
                             output int first_low, output bit last_en);
    nb = 0; low_n = 0; first_low = -1; last_en = 1'b0;
    while (busy === 1'b1 && nb < 200) begin
      if (cpu_reset === 1'b0) begin
        if (first_low < 0) first_low = nb;
        low_n++;
      end
      last_en = cpu_clk_enable;
      start   = (nb == start_at);
      nb++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic scen_halt7(input string tag);
    int nb, low_n, first_low;
    bit last_en;
    v0_rand = 1'b0;
    v0_val  = 32'd5;
    launch(1'b0, 7);
    run_to_done(-1, nb, low_n, first_low, last_en);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd10);
    check({tag, "_reset_low_n"}, 32'(low_n), 32'd8);
    check({tag, "_reset_low_at"}, 32'(first_low), 32'd2);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_result"}, result_v0, 32'd5);
    check({tag, "_count"}, cycle_count, 32'd7);
    v0_rand = 1'b1;
  endtask

  initial begin
    int nb, low_n, first_low;
    bit last_en;
    logic [31:0] mask;

    tick();
    cmp_on = 1'b1;
    check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reset_enable",    32'(cpu_clk_enable), 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_count",     cycle_count, 32'd0);
    reset = 1'b0;
    tick();

    // Free run, halt fetched on enabled cycle 7, v0 = 5.
    scen_halt7("halt7");

    // Never halts: budget of 20 enabled cycles.
    launch(1'b0, 0);
    run_to_done(-1, nb, low_n, first_low, last_en);
    check("budget_busy_cycles", 32'(nb), 32'(RC + MAXC + 1));
    check("budget_timeout", 32'(timeout), 32'd1);
    check("budget_count", cycle_count, 32'd20);
    check("budget_capture_enable", 32'(last_en), 32'd0);
    check("budget_done", 32'(done), 32'd1);

    // Single-step: steps in RUN cycles 3, 10, 11 grant cycles 4, 11, 12.
    launch(1'b1, 0);
    tick();
    tick();
    mask = 32'h0;
    for (int r = 1; r <= 15; r++) begin
      step = (r == 3 || r == 10 || r == 11);
      if (cpu_clk_enable === 1'b1) mask = mask | (32'd1 << r);
      tick();
    end
    step = 1'b0;
    check("step_grants", mask, 32'h0000_1810);
    check("step_count", cycle_count, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("step_abort_busy", 32'(busy), 32'd0);

    // Abort in free-run RUN cycle 4, then restart.
    launch(1'b0, 0);
    tick();
    tick();
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_enable", 32'(cpu_clk_enable), 32'd0);
    check("abort_count_held", cycle_count, 32'd4);
    launch(1'b0, 9);
    check("restart_count_clear", cycle_count, 32'd0);
    check("restart_in_rst", {30'd0, busy, cpu_reset}, 32'd3);
    run_to_done(-1, nb, low_n, first_low, last_en);
    check("restart_count", cycle_count, 32'd9);

    // Halt on the same cycle the budget is reached; start while busy ignored.
    launch(1'b0, MAXC);
    run_to_done(4, nb, low_n, first_low, last_en);
    check("edge_busy_cycles", 32'(nb), 32'(RC + MAXC + 1));
    check("edge_timeout", 32'(timeout), 32'd0);
    check("edge_count", cycle_count, 32'd20);

    // Synchronous reset mid-run, then repeat the first program.
    launch(1'b0, 7);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midreset_flags", {27'd0, cpu_clk_enable, busy, done, timeout, 1'b0}, 32'd0);
    check("midreset_result", result_v0, 32'd0);
    check("midreset_count", cycle_count, 32'd0);
    scen_halt7("after_reset");

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if (start) begin
        halt_at   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 25));
        step_mode = $urandom_range(0, 1) == 1;
      end
      abort = ($urandom_range(0, 49) == 0);
      step  = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    step  = 1'b0;
    reset = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "bench watchdog expired");
  end

endmodule
